// File: rtl/apb_bridge_pkg.sv
// Shared types for the CPU-to-APB master bridge.
//   state_e : bridge FSM states (IDLE, SETUP, ACCESS)
//   resp_e  : coded completion response reported on resp_o
//   idx_width(): width of a binary slave index for n slaves
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    RESP_OK      = 2'b00,
    RESP_SLVERR  = 2'b01,
    RESP_DECERR  = 2'b10,
    RESP_TIMEOUT = 2'b11
  } resp_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational priority address decoder.
//   addr_i       : address to decode
//   start_addr_i : packed per-slave window starts (inclusive), slave i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   end_addr_i   : packed per-slave window ends (inclusive)
//   hit_o        : address falls in at least one window
//   sel_o        : one-hot select of the winning window (lowest index wins on overlap)
//   idx_o        : binary index of the winning window
module apb_addr_decoder
  import apb_bridge_pkg::*;
#(
  parameter int NB_SLAVE   = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_W      = idx_width(NB_SLAVE)
) (
  input  logic [ADDR_WIDTH-1:0]          addr_i,
  input  logic [NB_SLAVE*ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_SLAVE*ADDR_WIDTH-1:0] end_addr_i,
  output logic                           hit_o,
  output logic [NB_SLAVE-1:0]            sel_o,
  output logic [IDX_W-1:0]               idx_o
);

  always_comb begin
    hit_o = 1'b0;
    sel_o = '0;
    idx_o = '0;
    for (int unsigned i = 0; i < NB_SLAVE; i++) begin
      if (!hit_o &&
          addr_i >= start_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] &&
          addr_i <= end_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit_o    = 1'b1;
        sel_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// CPU-to-APB master bridge: accepts one single-cycle request, decodes it
// against NB_SLAVE address windows and runs a full APB SETUP/ACCESS transfer.
//   clk, rst            : clock, synchronous active-high reset
//   req_i/we_i/addr_i/wdata_i : request (sampled only while ready_o=1)
//   ready_o             : bridge idle
//   done_o/rdata_o/resp_o : completion pulse, read data (held), coded response
//   start_addr_i/end_addr_i : packed static address windows
//   psel_o/penable_o/pwrite_o/paddr_o/pwdata_o : APB request side
//   prdata_i/pready_i/pslverr_i : packed per-slave APB response side
module apb_master_bridge
  import apb_bridge_pkg::*;
#(
  parameter int NB_SLAVE       = 5,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_i,
  input  logic                           we_i,
  input  logic [ADDR_WIDTH-1:0]          addr_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  output logic                           ready_o,
  output logic                           done_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [1:0]                     resp_o,
  input  logic [NB_SLAVE*ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_SLAVE*ADDR_WIDTH-1:0] end_addr_i,
  output logic [NB_SLAVE-1:0]            psel_o,
  output logic                           penable_o,
  output logic                           pwrite_o,
  output logic [ADDR_WIDTH-1:0]          paddr_o,
  output logic [DATA_WIDTH-1:0]          pwdata_o,
  input  logic [NB_SLAVE*DATA_WIDTH-1:0] prdata_i,
  input  logic [NB_SLAVE-1:0]            pready_i,
  input  logic [NB_SLAVE-1:0]            pslverr_i
);

  localparam int IDX_W = idx_width(NB_SLAVE);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Count value seen on the last permitted ACCESS cycle.
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e                  state_q,   state_d;
  logic [NB_SLAVE-1:0]     psel_q,    psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q,  pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q,   paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q,  pwdata_d;
  logic [IDX_W-1:0]        idx_q,     idx_d;
  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic                    done_q,    done_d;
  logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;
  resp_e                   resp_q,    resp_d;

  logic                    dec_hit;
  logic [NB_SLAVE-1:0]     dec_sel;
  logic [IDX_W-1:0]        dec_idx;
  logic [DATA_WIDTH-1:0]   prdata_sel;

  apb_addr_decoder #(
    .NB_SLAVE   (NB_SLAVE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (IDX_W)
  ) u_dec (
    .addr_i       (addr_i),
    .start_addr_i (start_addr_i),
    .end_addr_i   (end_addr_i),
    .hit_o        (dec_hit),
    .sel_o        (dec_sel),
    .idx_o        (dec_idx)
  );

  assign prdata_sel = prdata_i[idx_q*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d    = state_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    idx_d      = idx_q;
    wait_cnt_d = wait_cnt_q;
    done_d     = 1'b0;
    rdata_d    = rdata_q;
    resp_d     = resp_q;

    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          pwrite_d = we_i;
          paddr_d  = addr_i;
          pwdata_d = wdata_i;
          idx_d    = dec_idx;
          if (dec_hit) begin
            state_d    = SETUP;
            psel_d     = dec_sel;
            penable_d  = 1'b0;
            wait_cnt_d = '0;
          end else begin
            // Decode miss completes directly from IDLE without touching APB.
            done_d  = 1'b1;
            resp_d  = RESP_DECERR;
            rdata_d = '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // Ready is tested before the timeout so it wins on the last cycle.
        if (pready_i[idx_q]) begin
          if (!pwrite_q) begin
            rdata_d = prdata_sel;
          end
          resp_d    = pslverr_i[idx_q] ? RESP_SLVERR : RESP_OK;
          done_d    = 1'b1;
          state_d   = IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
        end else if (TIMEOUT_CYCLES != 0 && wait_cnt_q == CNT_LAST) begin
          resp_d    = RESP_TIMEOUT;
          done_d    = 1'b1;
          state_d   = IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      psel_q     <= '0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      idx_q      <= '0;
      wait_cnt_q <= '0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
      resp_q     <= RESP_OK;
    end else begin
      state_q    <= state_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      idx_q      <= idx_d;
      wait_cnt_q <= wait_cnt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      resp_q     <= resp_d;
    end
  end

  assign ready_o   = (state_q == IDLE);
  assign done_o    = done_q;
  assign rdata_o   = rdata_q;
  assign resp_o    = resp_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: five slaves with per-slave programmable wait
// states, table of directed transfers, plus back-to-back and reset sequences.
module tb_apb_master_bridge;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_i = 1'b0;
  logic         we_i = 1'b0;
  logic [31:0]  addr_i = '0;
  logic [31:0]  wdata_i = '0;
  logic         ready_o;
  logic         done_o;
  logic [31:0]  rdata_o;
  logic [1:0]   resp_o;
  logic [159:0] start_addr;
  logic [159:0] end_addr;
  logic [4:0]   psel_o;
  logic         penable_o;
  logic         pwrite_o;
  logic [31:0]  paddr_o;
  logic [31:0]  pwdata_o;
  logic [159:0] prdata;
  logic [4:0]   pready;
  logic [4:0]   pslverr_cfg = '0;

  int wait_cfg [5];
  int acc_cnt  [5];
  int tests = 0;
  int fails = 0;

  // Windows: slave2 overlaps slave0 over 0x600-0x6FF.
  assign start_addr = {32'h900, 32'h800, 32'h600, 32'h400, 32'h600};
  assign end_addr   = {32'h9FF, 32'h8FF, 32'h7FF, 32'h4FF, 32'h6FF};
  assign prdata     = {32'h44440004, 32'h33330003, 32'h22220002, 32'h11110001, 32'hDEADBEEF};

  always #5 clk = ~clk;

  apb_master_bridge #(
    .NB_SLAVE       (5),
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .ready_o      (ready_o),
    .done_o       (done_o),
    .rdata_o      (rdata_o),
    .resp_o       (resp_o),
    .start_addr_i (start_addr),
    .end_addr_i   (end_addr),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .pwrite_o     (pwrite_o),
    .paddr_o      (paddr_o),
    .pwdata_o     (pwdata_o),
    .prdata_i     (prdata),
    .pready_i     (pready),
    .pslverr_i    (pslverr_cfg)
  );

  // Slave model: holds pready low for wait_cfg[i] ACCESS cycles.
  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (!psel_o[i]) acc_cnt[i] <= 0;
      else if (penable_o && !pready[i]) acc_cnt[i] <= acc_cnt[i] + 1;
    end
  end

  always_comb begin
    pready = '0;
    for (int i = 0; i < 5; i++) pready[i] = (acc_cnt[i] >= wait_cfg[i]);
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          slv;
    int          waits;
    logic        slverr;
    logic [4:0]  psel;
    int          lat;
    int          acc;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [4:0] psel_seen;
    int         acc_seen;
    int         lat;
    logic       stable;
    for (int i = 0; i < 5; i++) wait_cfg[i] = 0;
    wait_cfg[v.slv] = v.waits;
    // Unselected slaves flag errors to prove they are ignored.
    pslverr_cfg = v.slverr ? (5'b1 << v.slv) : ~(5'b1 << v.slv);
    @(negedge clk);
    chk($sformatf("v%0d.ready", id), 64'(ready_o), 64'(1));
    req_i = 1'b1; we_i = v.we; addr_i = v.addr; wdata_i = v.wdata;
    @(posedge clk);
    #1 req_i = 1'b0;
    psel_seen = '0; acc_seen = 0; lat = 0; stable = 1'b1;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      psel_seen |= psel_o;
      if (psel_o != 0 && penable_o) acc_seen++;
      if (psel_o != 0 && (paddr_o !== v.addr || pwrite_o !== v.we ||
                          (v.we && pwdata_o !== v.wdata))) stable = 1'b0;
      if (done_o) lat = k;
    end
    chk($sformatf("v%0d.psel", id),   64'(psel_seen), 64'(v.psel));
    chk($sformatf("v%0d.access", id), 64'(acc_seen),  64'(v.acc));
    chk($sformatf("v%0d.latency", id), 64'(lat),      64'(v.lat));
    chk($sformatf("v%0d.resp", id),   64'(resp_o),    64'(v.resp));
    chk($sformatf("v%0d.rdata", id),  64'(rdata_o),   64'(v.rdata));
    chk($sformatf("v%0d.stable", id), 64'(stable),    64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic done_seen;
    logic pen_seen;

    //            we    addr        wdata         slv wt  err   psel      lat acc resp   rdata
    vecs[0]  = '{1'b0, 32'h600, 32'h0,        0, 0,   1'b0, 5'b00001, 3, 1, 2'b00, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 32'h440, 32'h5A,       1, 3,   1'b0, 5'b00010, 6, 4, 2'b00, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 32'h000, 32'h0,        0, 0,   1'b0, 5'b00000, 1, 0, 2'b10, 32'h0};
    vecs[3]  = '{1'b0, 32'h850, 32'h0,        3, 255, 1'b0, 5'b01000, 6, 4, 2'b11, 32'h0};
    vecs[4]  = '{1'b0, 32'h860, 32'h0,        3, 3,   1'b0, 5'b01000, 6, 4, 2'b00, 32'h33330003};
    vecs[5]  = '{1'b0, 32'h900, 32'h0,        4, 0,   1'b1, 5'b10000, 3, 1, 2'b01, 32'h44440004};
    vecs[6]  = '{1'b0, 32'h650, 32'h0,        0, 0,   1'b0, 5'b00001, 3, 1, 2'b00, 32'hDEADBEEF};
    vecs[7]  = '{1'b0, 32'h750, 32'h0,        2, 0,   1'b0, 5'b00100, 3, 1, 2'b00, 32'h22220002};
    vecs[8]  = '{1'b1, 32'h9FF, 32'hCAFEF00D, 4, 1,   1'b0, 5'b10000, 4, 2, 2'b00, 32'h22220002};
    vecs[9]  = '{1'b0, 32'h3FF, 32'h0,        0, 0,   1'b0, 5'b00000, 1, 0, 2'b10, 32'h0};
    vecs[10] = '{1'b0, 32'h4FF, 32'h0,        1, 0,   1'b0, 5'b00010, 3, 1, 2'b00, 32'h11110001};

    for (int i = 0; i < 5; i++) wait_cfg[i] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.ready",   64'(ready_o),   64'(1));
    chk("rst.psel",    64'(psel_o),    64'(0));
    chk("rst.penable", 64'(penable_o), 64'(0));
    chk("rst.pwrite",  64'(pwrite_o),  64'(0));
    chk("rst.paddr",   64'(paddr_o),   64'(0));
    chk("rst.pwdata",  64'(pwdata_o),  64'(0));
    chk("rst.done",    64'(done_o),    64'(0));
    chk("rst.rdata",   64'(rdata_o),   64'(0));
    chk("rst.resp",    64'(resp_o),    64'(0));

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Back-to-back: new request on the done cycle, busy-time request ignored.
    for (int i = 0; i < 5; i++) wait_cfg[i] = 0;
    pslverr_cfg = 5'b10000;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h904;
    @(posedge clk);
    #1 req_i = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (done_o) lat = k;
    end
    chk("b2b.lat1",  64'(lat),     64'(3));
    chk("b2b.resp1", 64'(resp_o),  64'(1));
    chk("b2b.ready", 64'(ready_o), 64'(1));
    req_i = 1'b1; addr_i = 32'h600;
    @(posedge clk);
    #1 addr_i = 32'h000;
    @(negedge clk);
    chk("b2b.setup_psel",    64'(psel_o),    64'(5'b00001));
    chk("b2b.setup_penable", 64'(penable_o), 64'(0));
    @(negedge clk);
    chk("b2b.access_penable", 64'(penable_o), 64'(1));
    chk("b2b.access_paddr",   64'(paddr_o),   64'(32'h600));
    req_i = 1'b0;
    @(negedge clk);
    chk("b2b.done2",  64'(done_o),  64'(1));
    chk("b2b.resp2",  64'(resp_o),  64'(0));
    chk("b2b.rdata2", 64'(rdata_o), 64'(32'hDEADBEEF));
    @(negedge clk);
    chk("b2b.no_extra_done", 64'(done_o),  64'(0));
    chk("b2b.idle_psel",     64'(psel_o),  64'(0));
    chk("b2b.paddr_kept",    64'(paddr_o), 64'(32'h600));

    // Reset in the middle of an ACCESS phase.
    wait_cfg[3] = 255;
    pslverr_cfg = '0;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h800;
    @(posedge clk);
    #1 req_i = 1'b0;
    pen_seen = 1'b0;
    for (int k = 0; k < 5 && !pen_seen; k++) begin
      @(negedge clk);
      pen_seen = penable_o;
    end
    chk("mrst.reached_access", 64'(pen_seen), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("mrst.psel",    64'(psel_o),    64'(0));
    chk("mrst.penable", 64'(penable_o), 64'(0));
    chk("mrst.ready",   64'(ready_o),   64'(1));
    chk("mrst.done",    64'(done_o),    64'(0));
    chk("mrst.rdata",   64'(rdata_o),   64'(0));
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      done_seen |= done_o;
    end
    chk("mrst.no_done", 64'(done_seen), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
